fifo_axi_dist: RTL and testbench
================================

Name: fifo_axi_dist

Overview:
- Read-side (destination) end of the synchronous slave FIFO. Drains the FIFO through its dist-side signals (FIFO_empty, FIFO_rd_data, FIFO_rd_en) and presents the words downstream on a valid/ready stream toward the AXI channel logic.
- Hides the FIFO's one-cycle registered read latency with a 2-entry output buffer. Sustains 1 word/cycle when the FIFO is non-empty and m_ready is held high.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and m_data.
- CNT_WIDTH, 16, width of the delivered-beat counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- FIFO_empty  input  1  FIFO has no readable word.
- FIFO_rd_data  input  DATA_WIDTH  FIFO read word, valid the cycle after FIFO_rd_en.
- FIFO_rd_en  output  1  FIFO pop request.
- m_data  output  DATA_WIDTH  stream data (head of output buffer).
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts.
- buf_count  output  2  output-buffer occupancy, 0..2.
- beats_out  output  CNT_WIDTH  count of delivered beats (m_valid && m_ready), wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): buffer emptied, inflight flag cleared, beats_out=0, m_valid=0, m_data=0, buf_count=0.
  - FIFO_rd_en is combinational and forced 0 while rst_n=0.
  - A read issued in the cycle before reset is discarded; its data is not captured after reset.
- State: entries e0 (head) and e1, buf_count in {0,1,2}, inflight (1 bit, set the cycle after FIFO_rd_en).
- Definitions:
  - pop = m_valid && m_ready.
  - push = inflight; FIFO_rd_data is written into the buffer in the cycle inflight=1.
- FIFO_rd_en = rst_n && !FIFO_empty && (buf_count + inflight - pop) <= 1.
  - FIFO_rd_en is never asserted while FIFO_empty=1.
  - The buffer can never overflow. An overflow is an assertion failure.
- Buffer update per edge:
  - pop only: e0<=e1, count-1.
  - push only: write at index count, count+1.
  - push and pop with count=1: e0<=FIFO_rd_data.
  - push and pop with count=2: e0<=e1, e1<=FIFO_rd_data.
  - push and pop with count=0 cannot occur (m_valid=0).
- m_valid = (buf_count != 0), driven from registers. m_data = e0.
- Stream rules:
  - Once m_valid=1, m_valid and m_data hold until pop.
  - Strict FIFO order; no loss or duplication.
- Latency: FIFO non-empty and buffer empty in cycle 0 -> FIFO_rd_en=1 in cycle 0 -> word captured at the end of cycle 1 -> m_valid=1 in cycle 2.
- Throughput: with m_ready=1 and FIFO_empty=0, one pop and one rd_en every cycle in steady state.
- Backpressure: with m_ready=0, at most two words are held (buf_count + inflight <= 2); FIFO_rd_en then stays 0.
- FIFO goes empty mid-burst: FIFO_rd_en drops in the same cycle. Buffered words still drain.
- beats_out increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.

Decomposition:
- Package fifo_dist_pkg:
  - localparam DIST_BUF_DEPTH=2.
  - typedef logic [1:0] dist_cnt_t.
- Sub-module dist_skid_buf:
  - Contains the 2-entry register buffer with push/pop/count.
  - fifo_axi_dist holds the read-issue logic, inflight flag and beats_out.

Test Plan:
- Reset: FIFO holds 0x11 and rst_n=0 for 3 cycles -> FIFO_rd_en=0, m_valid=0, buf_count=0, beats_out=0 throughout.
- Single word: FIFO holds 0xA5, m_ready=1 -> rd_en in cycle 0, m_valid=1 with m_data=0xA5 in cycle 2, pop in cycle 2, beats_out=1 in cycle 3.
- Streaming: FIFO holds 0x01..0x10, m_ready=1 -> 16 beats on consecutive cycles, in order, rd_en never asserted with FIFO_empty=1.
- Backpressure: 8 words queued, m_ready=0 for 10 cycles -> exactly 2 rd_en pulses, buf_count=2, m_data=0x01 stable. After m_ready=1, beats 0x01..0x08 are delivered in order with no gaps.
- Random stall: m_ready toggling 50% over 200 words -> scoreboard order match, buf_count<=2, m_valid never drops without a pop.
- Edge cases:
  - CNT_WIDTH=4 with 17 beats -> beats_out wraps to 1.
  - rst_n=0 while inflight=1 with data 0x77 -> 0x77 never appears on m_data.

Source files
------------

// File: rtl/fifo_dist_pkg.sv
// Shared types and sizes for the read side (dist side) of the slave FIFO.
package fifo_dist_pkg;

    // Number of words the output buffer can hold.
    localparam int DIST_BUF_DEPTH = 2;

    // Occupancy of the output buffer, 0..DIST_BUF_DEPTH.
    typedef logic [1:0] dist_cnt_t;

endpackage : fifo_dist_pkg

// File: rtl/dist_skid_buf.sv
// Two-entry output buffer. It absorbs the FIFO's one-cycle read latency.
// e0 is the head and drives the stream. e1 holds the word behind it.
import fifo_dist_pkg::*;

module dist_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            count_o,
    output logic                  valid_o
);

    localparam dist_cnt_t FULL = dist_cnt_t'(DIST_BUF_DEPTH);

    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;
    dist_cnt_t             count_q, count_d;

    // Next-state computation. The head always advances on a pop, and a pushed word lands behind the survivors.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_d = wdata_i;
                end else begin
                    e1_d = wdata_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_d = wdata_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = wdata_i;
                end
            end
            default: ;
        endcase
    end

    // State registers. Reset empties the buffer and clears the head so m_data reads 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    // The read-issue logic upstream must never deliver a word into a full buffer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_i && !pop_i && count_q == FULL));
        end
    end

    assign head_o  = e0_q;
    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);

endmodule : dist_skid_buf

// File: rtl/fifo_axi_dist.sv
// Drains the slave FIFO and presents its words on a valid/ready stream.
// A read is issued only when the word it returns is guaranteed a slot in the
// output buffer. This allows one word per cycle with no overflow.
import fifo_dist_pkg::*;

module fifo_axi_dist #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  FIFO_empty,
    input  logic [DATA_WIDTH-1:0] FIFO_rd_data,
    output logic                  FIFO_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            buf_count,
    output logic [CNT_WIDTH-1:0]  beats_out
);

    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] beats_q, beats_d;
    dist_cnt_t            count;
    logic                 pop;
    logic [2:0]           occ_next;

    assign pop = m_valid && m_ready;

    // Words held or arriving after this edge. It is bounded by 2, so it never underflows because pop implies count >= 1.
    assign occ_next   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign FIFO_rd_en = rst_n && !FIFO_empty && (occ_next <= 3'd1);

    // Next state. A read issued now returns data next cycle, and the beat counter wraps naturally.
    always_comb begin
        inflight_d = FIFO_rd_en;
        beats_d    = beats_q + CNT_WIDTH'(pop);
    end

    // Control registers. Clearing inflight on reset discards any read already in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            beats_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            beats_q    <= beats_d;
        end
    end

    dist_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (inflight_q),
        .pop_i  (pop),
        .wdata_i(FIFO_rd_data),
        .head_o (m_data),
        .count_o(count),
        .valid_o(m_valid)
    );

    assign buf_count = count;
    assign beats_out = beats_q;

endmodule : fifo_axi_dist

// File: tb/tb_fifo_axi_dist.sv
// Directed bench for fifo_axi_dist with a small registered-read FIFO model.
module tb_fifo_axi_dist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        FIFO_empty;
    logic [7:0]  FIFO_rd_data = 8'h00;
    logic        FIFO_rd_en, FIFO_rd_en_w4;
    logic [7:0]  m_data, m_data_w4;
    logic        m_valid, m_valid_w4;
    logic        m_ready;
    logic [1:0]  buf_count, buf_count_w4;
    logic [15:0] beats_out;
    logic [3:0]  beats_w4;

    fifo_axi_dist #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .FIFO_empty(FIFO_empty), .FIFO_rd_data(FIFO_rd_data),
        .FIFO_rd_en(FIFO_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .buf_count(buf_count), .beats_out(beats_out)
    );

    // Narrow-counter instance fed identically; only its beat counter is examined.
    fifo_axi_dist #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .FIFO_empty(FIFO_empty), .FIFO_rd_data(FIFO_rd_data),
        .FIFO_rd_en(FIFO_rd_en_w4), .m_data(m_data_w4), .m_valid(m_valid_w4), .m_ready(m_ready),
        .buf_count(buf_count_w4), .beats_out(beats_w4)
    );

    // Upstream FIFO model: data appears the cycle after a read request.
    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush  = 1'b0;

    assign FIFO_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (FIFO_rd_en) begin
            FIFO_rd_data <= mem[rd_ptr[9:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] got_data [0:1023];
    int         got_cyc  [0:1023];
    int         got_n = 0;
    logic       prev_ok = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[9:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // One clock: stream checks at the falling edge, then return 2 time units after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            chk("rd_en_while_empty", 32'(FIFO_rd_en & FIFO_empty), 32'd0);
            chk("buf_count_max", 32'(buf_count > 2'd2), 32'd0);
            chk("valid_vs_count", 32'(m_valid), 32'(buf_count != 2'd0));
            if (prev_ok && prev_valid && !prev_ready) begin
                chk("valid_hold", 32'(m_valid), 32'd1);
                chk("data_hold", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready && got_n < 1024) begin
                got_data[got_n] = m_data;
                got_cyc[got_n]  = cyc;
                got_n++;
            end
        end
        prev_ok    = rst_n;
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_data  = m_data;
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic do_reset();
        flush   = 1'b1;
        rst_n   = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        flush = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int base, c0, pulses;

        // Reset: a word is waiting but nothing moves while rst_n is low
        rst_n   = 1'b0;
        m_ready = 1'b0;
        push(8'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rd_en", 32'(FIFO_rd_en), 32'd0);
            chk("rst_valid", 32'(m_valid), 32'd0);
            chk("rst_count", 32'(buf_count), 32'd0);
            chk("rst_beats", 32'(beats_out), 32'd0);
        end
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("post_rst_rd_en", 32'(FIFO_rd_en), 32'd1);
        tick();
        chk("post_rst_c1_valid", 32'(m_valid), 32'd0);
        tick();
        chk("post_rst_c2_valid", 32'(m_valid), 32'd1);
        chk("post_rst_c2_data", 32'(m_data), 32'h11);
        tick();
        chk("post_rst_beats", 32'(beats_out), 32'd1);

        // Single word latency
        do_reset();
        push(8'hA5);
        m_ready = 1'b1;
        #1;
        chk("single_rd_en_c0", 32'(FIFO_rd_en), 32'd1);
        tick();
        chk("single_valid_c1", 32'(m_valid), 32'd0);
        chk("single_rd_en_c1", 32'(FIFO_rd_en), 32'd0);
        tick();
        chk("single_valid_c2", 32'(m_valid), 32'd1);
        chk("single_data_c2", 32'(m_data), 32'hA5);
        chk("single_count_c2", 32'(buf_count), 32'd1);
        tick();
        chk("single_beats_c3", 32'(beats_out), 32'd1);
        chk("single_valid_c3", 32'(m_valid), 32'd0);

        // Streaming 0x01..0x10 at full rate
        do_reset();
        c0   = cyc;
        base = got_n;
        for (int i = 1; i <= 16; i++) push(8'(i));
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("stream_count", 32'(got_n - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("stream_data", 32'(got_data[base+i]), 32'(i + 1));
            chk("stream_cycle", 32'(got_cyc[base+i]), 32'(c0 + 2 + i));
        end
        chk("stream_beats", 32'(beats_out), 32'd16);

        // Backpressure: two reads then stop; head holds steady
        do_reset();
        for (int i = 1; i <= 8; i++) push(8'(i));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            pulses += int'(FIFO_rd_en);
            tick();
        end
        chk("bp_rd_pulses", 32'(pulses), 32'd2);
        chk("bp_count", 32'(buf_count), 32'd2);
        chk("bp_head", 32'(m_data), 32'h01);
        chk("bp_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        base = got_n;
        c0   = cyc;
        for (int i = 0; i < 12; i++) tick();
        chk("bp_drain_count", 32'(got_n - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("bp_drain_data", 32'(got_data[base+i]), 32'(i + 1));
            chk("bp_drain_cycle", 32'(got_cyc[base+i]), 32'(c0 + i));
        end
        chk("bp_beats", 32'(beats_out), 32'd8);

        // Random stalls over 200 words
        do_reset();
        base = got_n;
        for (int i = 0; i < 200; i++) push(8'((i * 37 + 5) & 255));
        for (int k = 0; k < 3000 && (got_n - base) < 200; k++) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rand_count", 32'(got_n - base), 32'd200);
        for (int i = 0; i < 200; i++) begin
            chk("rand_data", 32'(got_data[base+i]), 32'((i * 37 + 5) & 255));
        end
        chk("rand_beats", 32'(beats_out), 32'd200);
        m_ready = 1'b0;

        // 17 beats: a 4-bit counter wraps to 1
        do_reset();
        base = got_n;
        for (int i = 0; i < 17; i++) push(8'(8'h20 + i));
        m_ready = 1'b1;
        for (int i = 0; i < 22; i++) tick();
        chk("wrap_count", 32'(got_n - base), 32'd17);
        chk("wrap_beats_w4", 32'(beats_w4), 32'd1);
        chk("wrap_beats_w16", 32'(beats_out), 32'd17);

        // Reset while a read is in flight: 0x77 must be discarded
        do_reset();
        m_ready = 1'b1;
        push(8'h77);
        #1;
        chk("inflt_rd_en", 32'(FIFO_rd_en), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("inflt_valid", 32'(m_valid), 32'd0);
        chk("inflt_count", 32'(buf_count), 32'd0);
        chk("inflt_no77", 32'(m_data == 8'h77), 32'd0);
        rst_n = 1'b1;
        base = got_n;
        push(8'h5C);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("inflt_no77", 32'(m_data == 8'h77), 32'd0);
        end
        chk("inflt_after_count", 32'(got_n - base), 32'd1);
        chk("inflt_after_data", 32'(got_data[base]), 32'h5C);
        chk("inflt_after_beats", 32'(beats_out), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_axi_dist
